// File: rtl/dcache_pkg.sv
// dcache shared defines header and package: memory-bus encodings, FSM state
// encodings and cache geometry.
// Optional feature macro: DCACHE_STATS_EN (hit/miss counters on the top).
`ifndef DCACHE_DEFINES_SV
`define DCACHE_DEFINES_SV
`define TRUE                  1'b1
`define FALSE                 1'b0
`define MEM_READ              1'b0
`define MEM_WRITE             1'b1
`define DCACHE_ST_IDLE        3'd0
`define DCACHE_ST_COMPARE     3'd1
`define DCACHE_ST_WB_ISSUE    3'd2
`define DCACHE_ST_WB_STREAM   3'd3
`define DCACHE_ST_WB_WAIT     3'd4
`define DCACHE_ST_FILL_ISSUE  3'd5
`define DCACHE_ST_FILL_STREAM 3'd6
`define DCACHE_ST_FILL_WAIT   3'd7
`define DCACHE_LINES          8
`define DCACHE_WORDS          32
`define DCACHE_TAG_W          8
`endif

package dcache_pkg;
    typedef enum logic [2:0] {
        IDLE        = `DCACHE_ST_IDLE,
        COMPARE     = `DCACHE_ST_COMPARE,
        WB_ISSUE    = `DCACHE_ST_WB_ISSUE,
        WB_STREAM   = `DCACHE_ST_WB_STREAM,
        WB_WAIT     = `DCACHE_ST_WB_WAIT,
        FILL_ISSUE  = `DCACHE_ST_FILL_ISSUE,
        FILL_STREAM = `DCACHE_ST_FILL_STREAM,
        FILL_WAIT   = `DCACHE_ST_FILL_WAIT
    } state_e;

    localparam int LINES = `DCACHE_LINES;
    localparam int WORDS = `DCACHE_WORDS;
    localparam int TAG_W = `DCACHE_TAG_W;
endpackage

// File: rtl/dcache_data_array.sv
// dcache data storage: one synchronous write port, one combinational read port.
// No reset on the storage itself; line validity lives in the top.
module dcache_data_array #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

    // write port: fill beats and CPU write hits share it, muxed by the top
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache, 8 lines x 32
// words. Block transfers to memory are one enable pulse followed by a word
// stream. Optional feature macro: DCACHE_STATS_EN adds hit_count/miss_count.
`include "dcache_pkg.sv"

module dcache
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 16,
    parameter int BLOCK_OFFSET_WIDTH = 5,
    parameter int INDEX_WIDTH        = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_enable,
    output logic                  mem_rw,
    output logic                  mem_op_size,
    output logic                  mem_finishes_op,
    output logic [DATA_WIDTH-1:0] mem_data_write,
    input  logic                  mem_data_write_req_input,
    input  logic [DATA_WIDTH-1:0] mem_data_read,
    input  logic                  mem_data_read_valid,
`ifdef DCACHE_STATS_EN
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
`endif
    input  logic                  mem_finished
);
    localparam int TW     = ADDR_WIDTH - INDEX_WIDTH - BLOCK_OFFSET_WIDTH;
    localparam int NLINES = 1 << INDEX_WIDTH;
    localparam int AW     = INDEX_WIDTH + BLOCK_OFFSET_WIDTH;

    state_e state, state_nx;

    logic [ADDR_WIDTH-1:0]         addr_q;
    logic                          we_q;
    logic [DATA_WIDTH-1:0]         wdata_q, rdata_q;
    logic [NLINES-1:0]             valid_q, dirty_q;
    logic [NLINES-1:0][TW-1:0]     tag_q;
    logic [BLOCK_OFFSET_WIDTH:0]   beat_q;   // MSB set once a full line has streamed

    logic [INDEX_WIDTH-1:0]        idx;
    logic [TW-1:0]                 tag_in;
    logic [BLOCK_OFFSET_WIDTH-1:0] off;
    logic                          hit;

    logic                          arr_we;
    logic [AW-1:0]                 arr_waddr, arr_raddr;
    logic [DATA_WIDTH-1:0]         arr_wdata, arr_rdata;

    assign idx    = addr_q[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
    assign tag_in = addr_q[ADDR_WIDTH-1 -: TW];
    assign off    = addr_q[BLOCK_OFFSET_WIDTH-1:0];
    assign hit    = valid_q[idx] && (tag_q[idx] == tag_in);

    // block-only transfers; the write-request handshake from memory is unused
    assign mem_op_size     = `FALSE;
    assign mem_finishes_op = `FALSE;

    // the read-hit word is forwarded in the ready cycle; otherwise the last read
    assign cpu_rdata = (state == COMPARE && hit && !we_q) ? arr_rdata : rdata_q;

    dcache_data_array #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(AW)) u_data (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .raddr (arr_raddr),
        .rdata (arr_rdata)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state, memory-side outputs and data-array port muxing
    always_comb begin
        state_nx       = state;
        cpu_ready      = `FALSE;
        mem_enable     = `FALSE;
        mem_rw         = `MEM_READ;
        mem_addr       = '0;
        mem_data_write = '0;
        arr_we         = `FALSE;
        arr_waddr      = {idx, off};
        arr_wdata      = wdata_q;
        arr_raddr      = {idx, off};
        unique case (state)
            IDLE: begin
                if (cpu_req) state_nx = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    cpu_ready = `TRUE;
                    arr_we    = we_q;
                    state_nx  = IDLE;
                end else if (valid_q[idx] && dirty_q[idx]) begin
                    state_nx = WB_ISSUE;
                end else begin
                    state_nx = FILL_ISSUE;
                end
            end
            WB_ISSUE, WB_STREAM, WB_WAIT: begin
                mem_rw         = `MEM_WRITE;
                mem_addr       = {tag_q[idx], idx, {BLOCK_OFFSET_WIDTH{1'b0}}};
                mem_data_write = arr_rdata;
                if (state == WB_ISSUE) begin
                    mem_enable = `TRUE;
                    arr_raddr  = {idx, {BLOCK_OFFSET_WIDTH{1'b0}}};
                    state_nx   = WB_STREAM;
                end else begin
                    // WB_WAIT keeps the last word on the bus until memory is done
                    arr_raddr = (state == WB_WAIT) ? {idx, {BLOCK_OFFSET_WIDTH{1'b1}}}
                                                   : {idx, beat_q[BLOCK_OFFSET_WIDTH-1:0]};
                    if (mem_finished)
                        state_nx = FILL_ISSUE;
                    else if (state == WB_STREAM && &beat_q[BLOCK_OFFSET_WIDTH-1:0])
                        state_nx = WB_WAIT;
                end
            end
            FILL_ISSUE: begin
                mem_enable = `TRUE;
                mem_addr   = {tag_in, idx, {BLOCK_OFFSET_WIDTH{1'b0}}};
                state_nx   = FILL_STREAM;
            end
            FILL_STREAM, FILL_WAIT: begin
                mem_addr = {tag_in, idx, {BLOCK_OFFSET_WIDTH{1'b0}}};
                // beats beyond a full line are dropped
                if (mem_data_read_valid && !beat_q[BLOCK_OFFSET_WIDTH]) begin
                    arr_we    = `TRUE;
                    arr_waddr = {idx, beat_q[BLOCK_OFFSET_WIDTH-1:0]};
                    arr_wdata = mem_data_read;
                end
                if (mem_finished)
                    state_nx = COMPARE;
                else if (state == FILL_STREAM && beat_q[BLOCK_OFFSET_WIDTH])
                    state_nx = FILL_WAIT;
            end
            default: state_nx = IDLE;
        endcase
    end

    // request latch, line metadata, beat counter and read-data hold register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            tag_q   <= '0;
            beat_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (we_q) dirty_q[idx] <= 1'b1;
                        else      rdata_q      <= arr_rdata;
                    end
                end
                WB_ISSUE: beat_q <= 1;
                WB_STREAM, WB_WAIT: begin
                    beat_q <= beat_q + 1'b1;
                    if (mem_finished) dirty_q[idx] <= 1'b0;
                end
                FILL_ISSUE: beat_q <= '0;
                FILL_STREAM, FILL_WAIT: begin
                    if (mem_data_read_valid && !beat_q[BLOCK_OFFSET_WIDTH])
                        beat_q <= beat_q + 1'b1;
                    if (mem_finished) begin
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        tag_q[idx]   <= tag_in;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic refill_q;   // next COMPARE is the post-fill retry, not a new lookup

    // saturating hit/miss counters, one count per first COMPARE of a request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
            refill_q   <= 1'b0;
        end else begin
            if (state == IDLE && cpu_req)
                refill_q <= 1'b0;
            else if ((state == FILL_STREAM || state == FILL_WAIT) && mem_finished)
                refill_q <= 1'b1;
            if (state == COMPARE && !refill_q) begin
                if (hit) begin
                    if (hit_count != '1) hit_count <= hit_count + 1'b1;
                end else begin
                    if (miss_count != '1) miss_count <= miss_count + 1'b1;
                end
            end
        end
    end
`endif

    logic unused_ok;
    assign unused_ok = mem_data_write_req_input;
endmodule

// File: tb/tb_dcache.sv
// Directed self-checking bench for dcache with a behavioural block memory.
module tb_dcache;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        cpu_ready;
    logic [15:0] mem_addr;
    logic        mem_enable, mem_rw, mem_op_size, mem_finishes_op;
    logic [31:0] mem_data_write, mem_data_read;
    logic        mem_data_write_req_input, mem_data_read_valid, mem_finished;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    dcache dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .cpu_addr                 (cpu_addr),
        .cpu_req                  (cpu_req),
        .cpu_we                   (cpu_we),
        .cpu_wdata                (cpu_wdata),
        .cpu_rdata                (cpu_rdata),
        .cpu_ready                (cpu_ready),
        .mem_addr                 (mem_addr),
        .mem_enable               (mem_enable),
        .mem_rw                   (mem_rw),
        .mem_op_size              (mem_op_size),
        .mem_finishes_op          (mem_finishes_op),
        .mem_data_write           (mem_data_write),
        .mem_data_write_req_input (mem_data_write_req_input),
        .mem_data_read            (mem_data_read),
        .mem_data_read_valid      (mem_data_read_valid),
`ifdef DCACHE_STATS_EN
        .hit_count                (hit_count),
        .miss_count               (miss_count),
`endif
        .mem_finished             (mem_finished)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:65535];
    logic [31:0] wb_buf [0:31];
    int          checks = 0;
    int          errors = 0;
    int          n_rd, n_wr, cycles;
    logic [15:0] wb_addr, fill_addr;
    logic [31:0] rd_data;

    function automatic logic [31:0] memval(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, cpu_ready}, 32'd0);
        chk({tag, "_rdata"}, cpu_rdata, 32'd0);
        chk({tag, "_men"},   {29'd0, mem_enable, mem_rw, mem_op_size | mem_finishes_op}, 32'd0);
        chk({tag, "_maddr"}, {16'd0, mem_addr}, 32'd0);
        chk({tag, "_mdata"}, mem_data_write, 32'd0);
    endtask

    // One CPU access with the memory model serviced every cycle. cycles counts
    // the request cycle as 1. abort_at >= 0 pulls reset after that many fill beats.
    task automatic access(input logic [15:0] a, input logic we, input logic [31:0] wd,
                          input int nbeats, input int abort_at, input string tag);
        int   mode, beat, dly, cyc;
        logic done;
        n_rd = 0; n_wr = 0; cycles = 0; mode = 0; beat = 0; dly = 0; cyc = 1; done = 1'b0;
        rd_data = 'x;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = a; cpu_we = we; cpu_wdata = wd;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            cpu_req             = 1'b0;
            mem_finished        = 1'b0;
            mem_data_read_valid = 1'b0;
            mem_data_read       = '0;
            if (cpu_ready) begin
                rd_data = cpu_rdata; cycles = cyc; done = 1'b1;
            end
            if (mem_enable) begin
                if (mem_rw) begin
                    n_wr++; wb_addr = mem_addr; wb_buf[0] = mem_data_write; beat = 1; mode = 1;
                end else begin
                    n_rd++; fill_addr = mem_addr; beat = 0; dly = 2; mode = 2;
                end
            end else if (mode == 1) begin
                wb_buf[beat] = mem_data_write;
                beat++;
                if (beat == 32) begin
                    mem_finished = 1'b1; mode = 0;
                    for (int k = 0; k < 32; k++) mem[16'(wb_addr + k)] = wb_buf[k];
                end
            end else if (mode == 2) begin
                if (dly > 0) begin
                    dly--;
                end else if (abort_at >= 0 && beat == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk_idle_outputs({tag, "_rst"});
                    @(negedge clk);
                    rst_n = 1'b1;
                    done  = 1'b1;
                end else if (beat < nbeats) begin
                    mem_data_read_valid = 1'b1;
                    mem_data_read       = mem[16'(fill_addr + beat)];
                    beat++;
                end else begin
                    mem_finished = 1'b1; mode = 0;
                end
            end
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = memval(16'(i));
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_data_write_req_input = 1'b0; mem_data_read = '0;
        mem_data_read_valid = 1'b0; mem_finished = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
`ifdef DCACHE_STATS_EN
        chk("reset_hits", hit_count, 32'd0);
        chk("reset_miss", miss_count, 32'd0);
`endif
        rst_n = 1'b1;

        // cold read: one fill of line 0x1220
        access(16'h1234, 1'b0, '0, 32, -1, "cold");
        chk("cold_rdata", rd_data, memval(16'h1234));
        chk("cold_nrd", n_rd, 1);
        chk("cold_nwr", n_wr, 0);
        chk("cold_faddr", {16'd0, fill_addr}, 32'h1220);

        // write hit: no traffic, rdata keeps the previous read
        access(16'h1234, 1'b1, 32'hDEADBEEF, 32, -1, "wrhit");
        chk("wrhit_lat", cycles, 2);
        chk("wrhit_traffic", n_rd + n_wr, 0);
        chk("wrhit_rdata", rd_data, memval(16'h1234));

        // read hit of the written word
        access(16'h1234, 1'b0, '0, 32, -1, "rdhit");
        chk("rdhit_rdata", rd_data, 32'hDEADBEEF);
        chk("rdhit_lat", cycles, 2);
        chk("rdhit_traffic", n_rd + n_wr, 0);

        // dirty eviction: write-back of 0x1220 then fill of 0x2220
        access(16'h2234, 1'b0, '0, 32, -1, "evict");
        chk("evict_nwr", n_wr, 1);
        chk("evict_nrd", n_rd, 1);
        chk("evict_wbaddr", {16'd0, wb_addr}, 32'h1220);
        chk("evict_wb0", wb_buf[0], memval(16'h1220));
        chk("evict_wb20", wb_buf[20], 32'hDEADBEEF);
        chk("evict_wb31", wb_buf[31], memval(16'h123F));
        chk("evict_faddr", {16'd0, fill_addr}, 32'h2220);
        chk("evict_rdata", rd_data, memval(16'h2234));
`ifdef DCACHE_STATS_EN
        chk("stats_hits", hit_count, 32'd2);
        chk("stats_miss", miss_count, 32'd2);
`endif

        // clean miss back to 0x1234: no write-back, written-back data returns
        access(16'h1234, 1'b0, '0, 32, -1, "clean");
        chk("clean_nwr", n_wr, 0);
        chk("clean_nrd", n_rd, 1);
        chk("clean_rdata", rd_data, 32'hDEADBEEF);

        // 33 valid beats: the extra one must not land anywhere in the line
        access(16'h3040, 1'b0, '0, 33, -1, "extra");
        chk("extra_rdata", rd_data, memval(16'h3040));
        access(16'h3040, 1'b0, '0, 32, -1, "extra0");
        chk("extra0_rdata", rd_data, memval(16'h3040));
        chk("extra0_traffic", n_rd + n_wr, 0);
        access(16'h305F, 1'b0, '0, 32, -1, "extra31");
        chk("extra31_rdata", rd_data, memval(16'h305F));

        // write miss allocates the line, then the write lands
        access(16'h5004, 1'b1, 32'hCAFEF00D, 32, -1, "wmiss");
        chk("wmiss_nrd", n_rd, 1);
        access(16'h5004, 1'b0, '0, 32, -1, "wmiss_rd");
        chk("wmiss_rdata", rd_data, 32'hCAFEF00D);
        access(16'h5005, 1'b0, '0, 32, -1, "wmiss_nb");
        chk("wmiss_nb_rdata", rd_data, memval(16'h5005));

        // reset at fill beat 10: transfer abandoned, the same read re-fills
        access(16'h4060, 1'b0, '0, 32, 10, "abort");
`ifdef DCACHE_STATS_EN
        chk("abort_hits", hit_count, 32'd0);
        chk("abort_miss", miss_count, 32'd0);
`endif
        access(16'h4060, 1'b0, '0, 32, -1, "refill");
        chk("refill_nrd", n_rd, 1);
        chk("refill_faddr", {16'd0, fill_addr}, 32'h4060);
        chk("refill_rdata", rd_data, memval(16'h4060));
        access(16'h1234, 1'b0, '0, 32, -1, "postrst");
        chk("postrst_nrd", n_rd, 1);
        chk("postrst_rdata", rd_data, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
